// File: rtl/div_defs.sv
// Shared definitions for the sequential divider: default operand widths
// (matching the 4x4 multiplier) and the FSM state encoding.
package div_defs;
  localparam int DIV_DW = 8;
  localparam int DIV_DV = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// conditionally subtract the divisor at DV+1 bits.
module div_step #(
  parameter int DV = 4
) (
  input  logic [DV:0]   i_rem,
  input  logic          i_bit,
  input  logic [DV-1:0] i_divisor,
  output logic [DV:0]   o_rem,
  output logic          o_qbit
);
  logic [DV:0] w_shift;
  logic [DV:0] w_dvs;
  logic        w_ge;

  assign w_shift = {i_rem[DV-1:0], i_bit};
  assign w_dvs   = {1'b0, i_divisor};
  // A set top bit means the true shifted value already exceeds any divisor.
  assign w_ge    = i_rem[DV] | (w_shift >= w_dvs);
  assign o_rem   = w_ge ? (w_shift - w_dvs) : w_shift;
  assign o_qbit  = w_ge;
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. The dividend register doubles as the quotient register.
module sequential_divider
  import div_defs::*;
#(
  parameter int DW = DIV_DW,
  parameter int DV = DIV_DV
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DV-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DV-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW + 1);

  state_t        r_state;
  logic [DW-1:0] r_shift;
  logic [DV-1:0] r_divisor;
  logic [DV:0]   r_rem;
  logic [CW-1:0] r_count;
  logic [DV:0]   w_rem_next;
  logic          w_qbit;

  div_step #(.DV(DV)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_shift[DW-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= dividend;
            r_divisor <= divisor;
            r_rem     <= '0;
            r_count   <= CW'(DW);
            busy      <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_divisor == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            // Dividend bits leave at the top while quotient bits enter at the bottom.
            r_rem   <= w_rem_next;
            r_shift <= {r_shift[DW-2:0], w_qbit};
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              quotient    <= {r_shift[DW-2:0], w_qbit};
              remainder   <= w_rem_next[DV-1:0];
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_sequential_divider;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         due;
    bit         prop;
    logic [7:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];

  sequential_divider #(.DW(8), .DV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   prod;
        bit   ok;
        e = sb.pop_front();
        chk("done_latency", cyc, e.due);
        chk("busy_at_done", busy, 1);
        if (e.prop) begin
          prod = int'(quotient) * int'(e.b) + int'(remainder);
          ok = (prod == int'(e.a)) && (remainder < e.b) && !div_by_zero;
          chk($sformatf("exh_%0d_div_%0d", e.a, e.b), ok, 1);
        end else begin
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                       input logic [3:0] er, input logic ed, input bit prop, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = ed; e.prop = prop; e.a = a; e.b = b;
      e.due = cyc + ((b == 4'd0) ? 2 : 9);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 4'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Basic division and exact latency
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    wait_idle();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Divide by zero
    issue(8'd77, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Start while busy is ignored
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    dividend = 8'd100;
    divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("no_requeue_busy", busy, 0);

    // Asynchronous reset mid-run
    issue(8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_idle", busy, 0);
    issue(8'd60, 4'd4, 8'd15, 4'd0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Every nonzero operand pair against q*d + r == a, r < d
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b), 8'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        wait_idle();
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
